// File: rtl/dense_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dense_pkg
// Description : Shared types and elaboration-time helpers for the quantized
//               dense-layer sequencer: FSM state encoding, counter widths,
//               accumulator sizing and saturation bounds.
// Revision    : 1.0 - initial release
// ============================================================================
package dense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_B   = 3'd1,
        ST_RD_X     = 3'd2,
        ST_RD_W     = 3'd3,
        ST_LAST_ACC = 3'd4,
        ST_WRITE    = 3'd5,
        ST_DONE     = 3'd6
    } dense_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Width of a counter/index able to hold 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    // Full signed product width plus growth for n_in terms; the bias term
    // is absorbed by the same headroom (58 bits for 24-bit data, 784 inputs).
    function automatic int acc_width(input int dw, input int n_in);
        return 2 * dw + clog2(n_in);
    endfunction

    // Largest value representable in a w-bit two's-complement word.
    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a w-bit two's-complement word.
    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage : dense_pkg
`default_nettype wire

// File: rtl/dense_postproc.sv
`default_nettype none
// ============================================================================
// Module      : dense_postproc
// Description : Combinational output stage of the dense layer. Arithmetic
//               right shift of the accumulator (floor), optional ReLU, then
//               saturation to the signed DATA_WIDTH range.
// Revision    : 1.0 - initial release
// Config      : DENSE_RELU_EN - when defined, negative shifted values give 0
// Ports       : acc  in  ACC_WIDTH   signed accumulator
//               y    out DATA_WIDTH  signed, saturated result
// ============================================================================
module dense_postproc
    import dense_pkg::*;
#(
    parameter int ACC_WIDTH  = 58,
    parameter int DATA_WIDTH = 24,
    parameter int SHIFT      = 0
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] y
);

    // Saturation bounds, expressed at accumulator width for the compare and
    // at output width for the clamp value.
    localparam logic signed [ACC_WIDTH-1:0]  C_ACC_MAX = ACC_WIDTH'(sat_hi(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0]  C_ACC_MIN = ACC_WIDTH'(sat_lo(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] C_Y_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] C_Y_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] w_shifted;

    assign w_shifted = acc >>> SHIFT;

    always_comb begin
        y = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > C_ACC_MAX) begin
            y = C_Y_MAX;
        end else if (w_shifted < C_ACC_MIN) begin
            y = C_Y_MIN;
        end
`ifdef DENSE_RELU_EN
        if (w_shifted[ACC_WIDTH-1]) begin
            y = '0;
        end
`endif
    end

endmodule : dense_postproc
`default_nettype wire

// File: rtl/dense_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dense_layer_sequencer
// Description : Drives a single-port registered-read RAM to evaluate
//               Y[j] = sat((b[j] + sum_i X[i]*W[j][i]) >>> SHIFT) for every
//               neuron, writes Y[j] back to RAM and reports the argmax class.
//               Per neuron: LOAD_B, N_IN x (RD_X, RD_W), LAST_ACC, WRITE.
// Revision    : 1.0 - initial release
// Config      : DENSE_RELU_EN - ReLU before saturation (see dense_postproc)
// Ports       : clk         in   clock, rising edge
//               rst_n       in   asynchronous active-low reset
//               start       in   sampled only in IDLE, starts one inference
//               busy        out  high from first LOAD_B through DONE
//               done        out  one-cycle pulse at end of inference
//               pred_class  out  argmax of Y, valid from done to next start
//               mem_we      out  RAM write enable (WRITE state only)
//               mem_addr    out  RAM word address
//               mem_wdata   out  RAM write data
//               mem_rdata   in   RAM read data, one cycle after address
// ============================================================================
module dense_layer_sequencer
    import dense_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 14,
    parameter int                     DATA_WIDTH    = 24,
    parameter int                     N_IN          = 784,
    parameter int                     N_OUT         = 10,
    parameter logic [ADDRESS_WIDTH-1:0] X_BASE      = 14'h0000,
    parameter logic [ADDRESS_WIDTH-1:0] W_BASE      = 14'h0310,
    parameter logic [ADDRESS_WIDTH-1:0] B_BASE      = 14'h21B0,
    parameter logic [ADDRESS_WIDTH-1:0] Y_BASE      = 14'h21BA,
    parameter int                     ACC_WIDTH     = acc_width(DATA_WIDTH, N_IN),
    parameter int                     SHIFT         = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [cnt_width(N_OUT)-1:0]   pred_class,
    output logic                          mem_we,
    output logic [ADDRESS_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam int C_IW = cnt_width(N_IN);
    localparam int C_JW = cnt_width(N_OUT);
    localparam logic [C_IW-1:0] C_I_LAST = C_IW'(N_IN - 1);
    localparam logic [C_JW-1:0] C_J_LAST = C_JW'(N_OUT - 1);

    dense_state_t r_state;
    dense_state_t w_next;

    logic        [C_IW-1:0]          r_i;
    logic        [C_JW-1:0]          r_j;
    logic        [ADDRESS_WIDTH-1:0] r_row_off;   // j*N_IN, built by repeated addition
    logic signed [DATA_WIDTH-1:0]    r_x;
    logic signed [ACC_WIDTH-1:0]     r_acc;
    logic signed [DATA_WIDTH-1:0]    r_max;
    logic        [C_JW-1:0]          r_pred;

    logic signed [2*DATA_WIDTH-1:0]  w_prod;
    logic signed [ACC_WIDTH-1:0]     w_prod_ext;
    logic signed [ACC_WIDTH-1:0]     w_bias_ext;
    logic signed [DATA_WIDTH-1:0]    w_y;

    // The read data always answers the address issued one state earlier:
    // in RD_X it is W[j][i-1] (or the bias when i==0), in LAST_ACC it is
    // the final weight of the row.
    assign w_prod     = r_x * $signed(mem_rdata);
    assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_WIDTH-DATA_WIDTH){mem_rdata[DATA_WIDTH-1]}}, mem_rdata};

    dense_postproc #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (SHIFT)
    ) u_postproc (
        .acc (r_acc),
        .y   (w_y)
    );

    assign pred_class = r_pred;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and RAM-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_next = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                mem_addr = B_BASE + ADDRESS_WIDTH'(r_j);
                w_next   = ST_RD_X;
            end
            ST_RD_X: begin
                mem_addr = X_BASE + ADDRESS_WIDTH'(r_i);
                w_next   = ST_RD_W;
            end
            ST_RD_W: begin
                mem_addr = W_BASE + r_row_off + ADDRESS_WIDTH'(r_i);
                w_next   = (r_i == C_I_LAST) ? ST_LAST_ACC : ST_RD_X;
            end
            ST_LAST_ACC: begin
                // i is frozen at N_IN-1, so this repeats the last weight address.
                mem_addr = W_BASE + r_row_off + ADDRESS_WIDTH'(r_i);
                w_next   = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = Y_BASE + ADDRESS_WIDTH'(r_j);
                mem_wdata = w_y;
                w_next    = (r_j == C_J_LAST) ? ST_DONE : ST_LOAD_B;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counters, operand register, MAC, argmax
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i       <= '0;
            r_j       <= '0;
            r_row_off <= '0;
            r_x       <= '0;
            r_acc     <= '0;
            r_max     <= '0;
            r_pred    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_j       <= '0;
                        r_row_off <= '0;
                        r_max     <= '0;
                        r_pred    <= '0;
                    end
                end
                ST_LOAD_B: begin
                    r_i <= '0;
                end
                ST_RD_X: begin
                    if (r_i == '0) begin
                        r_acc <= w_bias_ext;
                    end else begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                end
                ST_RD_W: begin
                    r_x <= $signed(mem_rdata);
                    if (r_i != C_I_LAST) begin
                        r_i <= r_i + C_IW'(1);
                    end
                end
                ST_LAST_ACC: begin
                    r_acc <= r_acc + w_prod_ext;
                end
                ST_WRITE: begin
                    // Strict compare keeps the lower index on ties.
                    if ((r_j == '0) || (w_y > r_max)) begin
                        r_max  <= w_y;
                        r_pred <= r_j;
                    end
                    if (r_j != C_J_LAST) begin
                        r_j       <= r_j + C_JW'(1);
                        r_row_off <= r_row_off + ADDRESS_WIDTH'(N_IN);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : dense_layer_sequencer
`default_nettype wire
